// File: rtl/mrv1_core_pkg.sv
// Shared core types and sizing for the multithreaded front end.
// The itag allocator derives its default thread count and window size from here.
package mrv1_core_pkg;

    localparam int unsigned NUM_THREADS = 8;
    localparam int unsigned ITAG_WIDTH  = 4;
    localparam int unsigned TID_WIDTH   = $clog2(NUM_THREADS);
    localparam int unsigned CNT_WIDTH   = ITAG_WIDTH + 1;

    // Tags per thread; needs one bit more than an itag to represent a full window.
    localparam logic [CNT_WIDTH-1:0] ITAG_WINDOW = {1'b1, {ITAG_WIDTH{1'b0}}};

    typedef logic [TID_WIDTH-1:0]  tid_t;
    typedef logic [ITAG_WIDTH-1:0] itag_t;
    typedef logic [CNT_WIDTH-1:0]  itag_cnt_t;

endpackage

// File: rtl/mrv1_itag_ring.sv
// One thread's circular itag window: head/tail pointers and occupancy,
// updated by alloc, retire and flush strobes already decoded for this thread.
module mrv1_itag_ring
    import mrv1_core_pkg::*;
#(
    parameter  int unsigned ITAG_WIDTH_P = ITAG_WIDTH,
    localparam int unsigned CNT_WIDTH_LP = ITAG_WIDTH_P + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    alloc_i,
    input  logic                    ret_i,
    input  logic [ITAG_WIDTH_P-1:0] ret_cnt_i,
    input  logic                    flush_i,
    output logic [ITAG_WIDTH_P-1:0] head_o,
    output logic [ITAG_WIDTH_P-1:0] tail_o,
    output logic [CNT_WIDTH_LP-1:0] occ_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    ovf_o
);

    localparam logic [CNT_WIDTH_LP-1:0] WIN_LP      = {1'b1, {ITAG_WIDTH_P{1'b0}}};
    localparam logic [ITAG_WIDTH_P-1:0] ITAG_ONE_LP = {{(ITAG_WIDTH_P-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH_LP-1:0] CNT_ONE_LP  = {{(CNT_WIDTH_LP-1){1'b0}}, 1'b1};

    logic [ITAG_WIDTH_P-1:0] head_q, head_d;
    logic [ITAG_WIDTH_P-1:0] tail_q, tail_d;
    logic [CNT_WIDTH_LP-1:0] occ_q,  occ_d;
    logic [CNT_WIDTH_LP-1:0] occ_ret_s;
    logic                    ovf_s;

    // Next-state: retire first, then either flush (tail snaps to new head) or alloc.
    always_comb begin
        head_d    = head_q;
        occ_ret_s = occ_q;
        ovf_s     = 1'b0;
        if (ret_i) begin
            if ({1'b0, ret_cnt_i} > occ_q) begin
                // Over-retire: drop everything outstanding and flag it.
                head_d    = tail_q;
                occ_ret_s = {CNT_WIDTH_LP{1'b0}};
                ovf_s     = 1'b1;
            end else begin
                head_d    = head_q + ret_cnt_i;
                occ_ret_s = occ_q - {1'b0, ret_cnt_i};
            end
        end else begin
            head_d    = head_q;
            occ_ret_s = occ_q;
        end
        tail_d = flush_i ? head_d : (alloc_i ? (tail_q + ITAG_ONE_LP) : tail_q);
        occ_d  = flush_i ? {CNT_WIDTH_LP{1'b0}} : (alloc_i ? (occ_ret_s + CNT_ONE_LP) : occ_ret_s);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q <= {ITAG_WIDTH_P{1'b0}};
            tail_q <= {ITAG_WIDTH_P{1'b0}};
            occ_q  <= {CNT_WIDTH_LP{1'b0}};
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign head_o  = head_q;
    assign tail_o  = tail_q;
    assign occ_o   = occ_q;
    assign full_o  = (occ_q == WIN_LP);
    assign empty_o = (occ_q == {CNT_WIDTH_LP{1'b0}});
    assign ovf_o   = ovf_s;

endmodule

// File: rtl/mrv1_itag_ctrl.sv
// Per-thread itag allocator and retirement sequencer: decodes thread ids into
// per-ring strobes, muxes the dispatch tag, and holds the sticky over-retire error.
module mrv1_itag_ctrl
    import mrv1_core_pkg::*;
#(
    parameter  int unsigned NUM_THREADS_P = NUM_THREADS,
    parameter  int unsigned ITAG_WIDTH_P  = ITAG_WIDTH,
    localparam int unsigned TID_WIDTH_LP  = $clog2(NUM_THREADS_P),
    localparam int unsigned CNT_WIDTH_LP  = ITAG_WIDTH_P + 1
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        disp_vld_i,
    input  logic [TID_WIDTH_LP-1:0]                     disp_tid_i,
    output logic                                        disp_rdy_o,
    output logic [ITAG_WIDTH_P-1:0]                     disp_itag_o,
    input  logic                                        ret_vld_i,
    input  logic [TID_WIDTH_LP-1:0]                     ret_tid_i,
    input  logic [ITAG_WIDTH_P-1:0]                     ret_cnt_i,
    input  logic                                        flush_i,
    input  logic [TID_WIDTH_LP-1:0]                     flush_tid_i,
    output logic [NUM_THREADS_P-1:0][ITAG_WIDTH_P-1:0]  retire_itag_o,
    output logic [NUM_THREADS_P-1:0][CNT_WIDTH_LP-1:0]  thr_occ_o,
    output logic [NUM_THREADS_P-1:0]                    thr_full_o,
    output logic [NUM_THREADS_P-1:0]                    thr_empty_o,
    output logic                                        err_o
);

    logic [ITAG_WIDTH_P-1:0] tail_s [NUM_THREADS_P];
    logic [NUM_THREADS_P-1:0] alloc_s;
    logic [NUM_THREADS_P-1:0] ret_s;
    logic [NUM_THREADS_P-1:0] flush_s;
    logic [NUM_THREADS_P-1:0] ovf_s;
    logic                     disp_blk_s;
    logic                     err_q, err_d;

    // A flush of the requesting thread wins over its dispatch in the same cycle.
    assign disp_blk_s  = flush_i & (flush_tid_i == disp_tid_i);
    assign disp_rdy_o  = ~thr_full_o[disp_tid_i] & ~disp_blk_s;
    assign disp_itag_o = tail_s[disp_tid_i];

    for (genvar t = 0; t < NUM_THREADS_P; t++) begin : g_ring
        assign alloc_s[t] = disp_vld_i & disp_rdy_o & (disp_tid_i == TID_WIDTH_LP'(t));
        assign ret_s[t]   = ret_vld_i & (ret_tid_i == TID_WIDTH_LP'(t));
        assign flush_s[t] = flush_i & (flush_tid_i == TID_WIDTH_LP'(t));

        mrv1_itag_ring #(
            .ITAG_WIDTH_P (ITAG_WIDTH_P)
        ) u_ring (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .alloc_i   (alloc_s[t]),
            .ret_i     (ret_s[t]),
            .ret_cnt_i (ret_cnt_i),
            .flush_i   (flush_s[t]),
            .head_o    (retire_itag_o[t]),
            .tail_o    (tail_s[t]),
            .occ_o     (thr_occ_o[t]),
            .full_o    (thr_full_o[t]),
            .empty_o   (thr_empty_o[t]),
            .ovf_o     (ovf_s[t])
        );
    end

    assign err_d = err_q | (|ovf_s);

    // Sticky over-retire error, cleared only by reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_mrv1_itag_ctrl.sv
// Randomized and directed bench for mrv1_itag_ctrl against a per-thread
// arithmetic window model (head, tail, count as plain integers mod 16).
module tb_mrv1_itag_ctrl;

    localparam int NT  = 8;
    localparam int IW  = 4;
    localparam int TW  = 3;
    localparam int CW  = 5;
    localparam int WIN = 16;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     disp_vld;
    logic [TW-1:0]            disp_tid;
    logic                     disp_rdy;
    logic [IW-1:0]            disp_itag;
    logic                     ret_vld;
    logic [TW-1:0]            ret_tid;
    logic [IW-1:0]            ret_cnt;
    logic                     flush;
    logic [TW-1:0]            flush_tid;
    logic [NT-1:0][IW-1:0]    retire_itag;
    logic [NT-1:0][CW-1:0]    thr_occ;
    logic [NT-1:0]            thr_full;
    logic [NT-1:0]            thr_empty;
    logic                     err;

    always #5 clk = ~clk;

    mrv1_itag_ctrl dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .disp_vld_i    (disp_vld),
        .disp_tid_i    (disp_tid),
        .disp_rdy_o    (disp_rdy),
        .disp_itag_o   (disp_itag),
        .ret_vld_i     (ret_vld),
        .ret_tid_i     (ret_tid),
        .ret_cnt_i     (ret_cnt),
        .flush_i       (flush),
        .flush_tid_i   (flush_tid),
        .retire_itag_o (retire_itag),
        .thr_occ_o     (thr_occ),
        .thr_full_o    (thr_full),
        .thr_empty_o   (thr_empty),
        .err_o         (err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    int m_head [NT];
    int m_tail [NT];
    int m_occ  [NT];
    bit m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < NT; t++) begin
            m_head[t] = 0;
            m_tail[t] = 0;
            m_occ[t]  = 0;
        end
        m_err = 1'b0;
    endtask

    function automatic bit model_rdy(input int dt, input bit fl, input int ft);
        return (m_occ[dt] != WIN) && !(fl && (ft == dt));
    endfunction

    task automatic model_step(input bit dv, input int dt, input bit rv, input int rt,
                              input int rc, input bit fl, input int ft);
        bit rdy;
        rdy = model_rdy(dt, fl, ft);
        for (int t = 0; t < NT; t++) begin
            if (rv && rt == t) begin
                if (rc > m_occ[t]) begin
                    m_head[t] = m_tail[t];
                    m_occ[t]  = 0;
                    m_err     = 1'b1;
                end else begin
                    m_head[t] = (m_head[t] + rc) % WIN;
                    m_occ[t]  = m_occ[t] - rc;
                end
            end
            if (fl && ft == t) begin
                m_tail[t] = m_head[t];
                m_occ[t]  = 0;
            end else if (dv && rdy && dt == t) begin
                m_tail[t] = (m_tail[t] + 1) % WIN;
                m_occ[t]  = m_occ[t] + 1;
            end
        end
    endtask

    task automatic check_state(input string tag);
        logic [63:0] eh, eo, ef, ee;
        eh = '0; eo = '0; ef = '0; ee = '0;
        for (int t = 0; t < NT; t++) begin
            eh[t*IW +: IW] = IW'(m_head[t]);
            eo[t*CW +: CW] = CW'(m_occ[t]);
            ef[t]          = (m_occ[t] == WIN);
            ee[t]          = (m_occ[t] == 0);
        end
        chk({tag, "_head"},  64'(retire_itag), eh);
        chk({tag, "_occ"},   64'(thr_occ), eo);
        chk({tag, "_full"},  64'(thr_full), ef);
        chk({tag, "_empty"}, 64'(thr_empty), ee);
        chk({tag, "_err"},   64'(err), 64'(m_err));
    endtask

    // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
    task automatic cycle(input bit dv, input int dt, input bit rv, input int rt, input int rc,
                         input bit fl, input int ft, output logic [IW-1:0] g_itag, output logic g_rdy);
        disp_vld  = dv;
        disp_tid  = TW'(dt);
        ret_vld   = rv;
        ret_tid   = TW'(rt);
        ret_cnt   = IW'(rc);
        flush     = fl;
        flush_tid = TW'(ft);
        #2;
        g_itag = disp_itag;
        g_rdy  = disp_rdy;
        chk("rdy",  64'(disp_rdy),  64'(model_rdy(dt, fl, ft)));
        chk("itag", 64'(disp_itag), 64'(m_tail[dt]));
        @(posedge clk);
        model_step(dv, dt, rv, rt, rc, fl, ft);
        #1;
        check_state("st");
    endtask

    logic [IW-1:0] g_itag;
    logic          g_rdy;

    initial begin
        rst = 1'b1;
        disp_vld = 1'b0; disp_tid = '0; ret_vld = 1'b0; ret_tid = '0;
        ret_cnt = '0; flush = 1'b0; flush_tid = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_state("rst");
        chk("rst_rdy",  64'(disp_rdy),  64'd1);
        chk("rst_itag", 64'(disp_itag), 64'd0);
        rst = 1'b0;

        // Fill tid 3.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 3, 1'b0, 0, 0, 1'b0, 0, g_itag, g_rdy);
            chk("t1_itag", 64'(g_itag), 64'(i));
            chk("t1_rdy",  64'(g_rdy),  64'd1);
        end
        chk("t1_full", 64'(thr_full[3]), 64'd1);
        chk("t1_occ",  64'(thr_occ[3]),  64'd16);
        cycle(1'b1, 3, 1'b0, 0, 0, 1'b0, 0, g_itag, g_rdy);
        chk("t1_rdy17", 64'(g_rdy), 64'd0);

        // Retire 5 from full, then refill across the wrap.
        cycle(1'b0, 3, 1'b1, 3, 5, 1'b0, 0, g_itag, g_rdy);
        chk("t2_head", 64'(retire_itag[3]), 64'd5);
        chk("t2_occ",  64'(thr_occ[3]),     64'd11);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 3, 1'b0, 0, 0, 1'b0, 0, g_itag, g_rdy);
            chk("t2_itag", 64'(g_itag), 64'(i));
        end
        chk("t2_full", 64'(thr_full[3]), 64'd1);

        // Same-thread dispatch and retire.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1, 1'b0, 0, 0, 1'b0, 0, g_itag, g_rdy);
        cycle(1'b1, 1, 1'b1, 1, 2, 1'b0, 0, g_itag, g_rdy);
        chk("t3_occ",  64'(thr_occ[1]),     64'd3);
        chk("t3_head", 64'(retire_itag[1]), 64'd2);
        cycle(1'b0, 1, 1'b0, 0, 0, 1'b0, 0, g_itag, g_rdy);
        chk("t3_tail", 64'(g_itag), 64'd5);

        // Flush with same-cycle retire on tid 2, dispatch blocked for 2 but accepted for 4.
        for (int i = 0; i < 10; i++) cycle(1'b1, 2, 1'b0, 0, 0, 1'b0, 0, g_itag, g_rdy);
        cycle(1'b0, 2, 1'b1, 2, 10, 1'b0, 0, g_itag, g_rdy);
        for (int i = 0; i < 6; i++) cycle(1'b1, 2, 1'b0, 0, 0, 1'b0, 0, g_itag, g_rdy);
        chk("t4_pre_head", 64'(retire_itag[2]), 64'd10);
        chk("t4_pre_occ",  64'(thr_occ[2]),     64'd6);
        disp_vld = 1'b1; disp_tid = 3'd2; flush = 1'b1; flush_tid = 3'd2;
        ret_vld = 1'b1; ret_tid = 3'd2; ret_cnt = 4'd2;
        #1;
        chk("t4_blk", 64'(disp_rdy), 64'd0);
        cycle(1'b1, 4, 1'b1, 2, 2, 1'b1, 2, g_itag, g_rdy);
        chk("t4_rdy4", 64'(g_rdy),          64'd1);
        chk("t4_head", 64'(retire_itag[2]), 64'd12);
        chk("t4_occ",  64'(thr_occ[2]),     64'd0);
        chk("t4_occ4", 64'(thr_occ[4]),     64'd1);
        cycle(1'b0, 2, 1'b0, 0, 0, 1'b0, 0, g_itag, g_rdy);
        chk("t4_tail", 64'(g_itag), 64'd12);

        // Over-retire on tid 0.
        cycle(1'b1, 0, 1'b0, 0, 0, 1'b0, 0, g_itag, g_rdy);
        cycle(1'b1, 0, 1'b0, 0, 0, 1'b0, 0, g_itag, g_rdy);
        cycle(1'b0, 0, 1'b1, 0, 3, 1'b0, 0, g_itag, g_rdy);
        chk("t5_err",  64'(err),            64'd1);
        chk("t5_occ",  64'(thr_occ[0]),     64'd0);
        chk("t5_head", 64'(retire_itag[0]), 64'd2);
        cycle(1'b0, 0, 1'b0, 0, 0, 1'b0, 0, g_itag, g_rdy);
        chk("t5_sticky", 64'(err), 64'd1);
        chk("t5_tail",   64'(g_itag), 64'd2);

        // Random traffic concentrated on a few threads so windows fill and wrap.
        for (int n = 0; n < 3000; n++) begin
            bit dv, rv, fl;
            int dt, rt, rc, ft;
            dv = ($urandom % 4) != 0;
            dt = $urandom_range(0, 3);
            rv = ($urandom % 10) < 3;
            rt = $urandom_range(0, 3);
            rc = (($urandom % 100) < 80) ? $urandom_range(0, 3) : $urandom_range(0, 15);
            fl = ($urandom % 20) == 0;
            ft = $urandom_range(0, 3);
            cycle(dv, dt, rv, rt, rc, fl, ft, g_itag, g_rdy);
        end

        // Asynchronous reset in the middle of a dispatch burst.
        for (int i = 0; i < 3; i++) cycle(1'b1, 5, 1'b0, 0, 0, 1'b0, 0, g_itag, g_rdy);
        disp_vld = 1'b1; disp_tid = 3'd5; ret_vld = 1'b0; flush = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_state("arst");
        chk("arst_rdy",  64'(disp_rdy),  64'd1);
        chk("arst_itag", 64'(disp_itag), 64'd0);
        #1;
        rst = 1'b0;
        disp_vld = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b1, 5, 1'b0, 0, 0, 1'b0, 0, g_itag, g_rdy);
        chk("arst_first", 64'(g_itag), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
